// File: rtl/mel_band_accumulator_pkg.sv
// ============================================================================
// mel_band_accumulator_pkg : shared widths, FSM states and FIFO entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package mel_band_accumulator_pkg;

  localparam int P_WIDTH        = 16;
  localparam int ACC_WIDTH      = 24;
  localparam int N_MEL          = 26;
  localparam int MEL_FIFO_DEPTH = 4;
  localparam int IDX_WIDTH      = $clog2(N_MEL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } mel_state_t;

  typedef struct packed {
    logic [ACC_WIDTH-1:0] energy;
    logic [IDX_WIDTH-1:0] idx;
  } mel_entry_t;

  // Clamp to all-ones instead of wrapping when the carry-out is set.
  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [P_WIDTH-1:0]   prod);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, acc} + {{(ACC_WIDTH + 1 - P_WIDTH){1'b0}}, prod};
    return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/mel_band_accumulator_if.sv
// ============================================================================
// mel_band_accumulator_if : product input beats and band-energy output stream
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mel_band_accumulator_if;
  import mel_band_accumulator_pkg::*;

  logic                 i_valid;
  logic [P_WIDTH-1:0]   i_prod;
  logic                 i_last;
  logic                 i_frame_end;
  logic                 i_ready;
  logic                 o_valid;
  logic [ACC_WIDTH-1:0] o_energy;
  logic [IDX_WIDTH-1:0] o_idx;

  modport master (
    output i_valid, i_prod, i_last, i_frame_end, i_ready,
    input  o_valid, o_energy, o_idx
  );

  modport slave (
    input  i_valid, i_prod, i_last, i_frame_end, i_ready,
    output o_valid, o_energy, o_idx
  );

endinterface

`default_nettype wire

// File: rtl/mel_band_accumulator_out_fifo.sv
// ============================================================================
// mel_out_fifo : synchronous FIFO of band entries, push accepted when full+pop
// Revision: 1.0
// ============================================================================
`default_nettype none

module mel_out_fifo
  import mel_band_accumulator_pkg::*;
#(
  parameter int DEPTH = MEL_FIFO_DEPTH
) (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_push,
  input  wire mel_entry_t i_data,
  input  wire logic       i_pop,
  output logic            o_full,
  output logic            o_empty,
  output mel_entry_t      o_head
);

  localparam int AW = $clog2(DEPTH);

  mel_entry_t    r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_do_pop;
  logic          w_do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mel_band_accumulator.sv
// ============================================================================
// mel_band_accumulator : sums weighted bins per mel band, queues band energies
// Revision: 1.0
// ============================================================================
`default_nettype none

module mel_band_accumulator
  import mel_band_accumulator_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                rst,
  mel_band_accumulator_if.slave    bus,
  output logic                     o_frame_done,
  output logic                     o_overflow,
  output logic                     o_seq_err
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_MEL - 1);

  mel_state_t           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [IDX_WIDTH-1:0] r_band_idx;
  logic                 r_frame_done;
  logic                 r_overflow;
  logic                 r_seq_err;

  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [ACC_WIDTH-1:0] w_sum;
  mel_entry_t           w_entry;
  mel_entry_t           w_head;

  assign w_accept = bus.i_valid && (r_state != S_DRAIN);
  assign w_sum    = sat_add(r_acc, bus.i_prod);
  assign w_push   = w_accept && bus.i_last;
  assign w_pop    = bus.i_ready && !w_empty;
  assign w_entry  = '{energy: w_sum, idx: r_band_idx};

  mel_out_fifo #(.DEPTH(MEL_FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_band_idx   <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_accept) begin
            r_state <= S_ACCUM;
            if (bus.i_last) begin
              r_acc      <= '0;
              r_band_idx <= (r_band_idx == LAST_IDX) ? '0 : r_band_idx + 1'b1;
              if (bus.i_frame_end) begin
                r_state <= S_DRAIN;
                if (r_band_idx != LAST_IDX) begin
                  r_seq_err <= 1'b1;
                end
              end
            end else begin
              r_acc <= w_sum;
            end
          end
        end
        S_DRAIN: begin
          // Upstream has no backpressure, so a beat here is lost and flagged.
          if (bus.i_valid) begin
            r_seq_err <= 1'b1;
          end
          if (w_empty) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
            r_band_idx   <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_valid  = !w_empty;
  assign bus.o_energy = w_head.energy;
  assign bus.o_idx    = w_head.idx;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;
  assign o_seq_err    = r_seq_err;

endmodule

`default_nettype wire
